// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, prefetches program bytes into a FIFO.
// Optional stall counter enabled by defining FETCH_PERF_EN.
module instruction_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReq,
    input  logic              memAck,
    input  logic [7:0]        memRdata,
    output logic [7:0]        instr,
    output logic              instrValid,
    input  logic              instrTake,
    input  logic              jumpEn,
    input  logic [ADDR_W-1:0] jumpAddr
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       stallCnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jumpHold;
    logic              discard;
    logic [7:0]        fifo [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic              canIssue;
    logic              push;
    logic              take;

    assign canIssue   = count < CW'(DEPTH);
    assign push       = (state == S_WAIT) && memAck
                        && !discard && !jumpEn;
    assign instrValid = count != '0;
    assign take       = instrTake && instrValid && !jumpEn;
    assign instr      = instrValid ? fifo[rdPtr] : 8'h00;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= stateNext;
    end

    // Next state: issue only with a free slot, one request in flight
    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE: if (!jumpEn && canIssue) stateNext = S_WAIT;
            S_WAIT: if (memAck) stateNext = S_IDLE;
        endcase
    end

    // Outputs: request is Moore, address is the PC frozen during WAIT
    always_comb begin
        memReq  = (state == S_WAIT);
        memAddr = pc;
    end

    // PC and pending-jump bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            jumpHold <= '0;
            discard  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (jumpEn) pc <= jumpAddr;
                end
                S_WAIT: begin
                    if (memAck) begin
                        discard <= 1'b0;
                        if (jumpEn)       pc <= jumpAddr;
                        else if (discard) pc <= jumpHold;
                        else              pc <= pc + ADDR_W'(1);
                    end else if (jumpEn) begin
                        jumpHold <= jumpAddr;
                        discard  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a jump flushes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (jumpEn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (take) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(take);
        end
    end

    // FIFO storage, no reset needed since count gates the output
    always_ff @(posedge clk) begin
        if (push) fifo[wrPtr] <= memRdata;
    end

`ifdef FETCH_PERF_EN
    // Saturating count of cycles with nothing for decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stallCnt <= '0;
        else if (!instrValid && stallCnt != 16'hFFFF)
            stallCnt <= stallCnt + 16'd1;
    end
`endif

endmodule
